// File: rtl/alu_mdu.sv
// Single-issue ALU with an iterative multiply/divide unit and HI/LO registers.
// Simple ops complete in one cycle; MULTU/DIVU iterate one bit per cycle.
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       Func,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUout,
    output logic             Zero
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    localparam logic [3:0] F_AND  = 4'h0;
    localparam logic [3:0] F_OR   = 4'h1;
    localparam logic [3:0] F_ADD  = 4'h2;
    localparam logic [3:0] F_XOR  = 4'h3;
    localparam logic [3:0] F_NOR  = 4'h4;
    localparam logic [3:0] F_SLT  = 4'h5;
    localparam logic [3:0] F_SUB  = 4'h6;
    localparam logic [3:0] F_SLTU = 4'h7;
    localparam logic [3:0] F_SLL  = 4'h8;
    localparam logic [3:0] F_SRL  = 4'h9;
    localparam logic [3:0] F_SRA  = 4'hA;
    localparam logic [3:0] F_LUI  = 4'hB;
    localparam logic [3:0] F_MULT = 4'hC;
    localparam logic [3:0] F_DIVU = 4'hD;
    localparam logic [3:0] F_MFHI = 4'hE;
    localparam logic [3:0] F_MFLO = 4'hF;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] hi, lo;
    logic [WIDTH-1:0] work_hi, work_lo, opb;
    logic [SHW-1:0]   cnt;
    logic             last;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH:0]   mul_sum, div_shift, div_trial;
    logic             div_ge;
    logic [WIDTH-1:0] step_hi, step_lo;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    case (Func)
                        F_MULT:  state_nxt = MUL;
                        F_DIVU:  state_nxt = DIV;
                        default: state_nxt = DONE;
                    endcase
                end
            end
            MUL, DIV: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign last = (cnt == SHW'(WIDTH - 1));

    // ---------------- single-cycle datapath ----------------
    assign sh = In2[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (Func)
            F_AND:  alu_res = In1 & In2;
            F_OR:   alu_res = In1 | In2;
            F_ADD:  alu_res = In1 + In2;
            F_XOR:  alu_res = In1 ^ In2;
            F_NOR:  alu_res = ~(In1 | In2);
            F_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(In1) < $signed(In2))};
            F_SUB:  alu_res = In1 - In2;
            F_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (In1 < In2)};
            F_SLL:  alu_res = In1 << sh;
            F_SRL:  alu_res = In1 >> sh;
            F_SRA:  alu_res = $signed(In1) >>> sh;
            F_LUI:  alu_res = In2 << (WIDTH / 2);
            F_MFHI: alu_res = hi;
            F_MFLO: alu_res = lo;
            default: alu_res = '0;
        endcase
    end

    // ---------------- iterative mul/div step ----------------
    // Multiply: {work_hi, work_lo} is the product register, multiplier starts
    // in work_lo and is consumed from bit 0. Divide: work_hi is the partial
    // remainder, dividend bits shift out of work_lo while quotient bits shift in.
    // A zero divisor makes every trial succeed, giving all-ones / dividend.
    assign mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opb} : '0);
    assign div_shift = {work_hi, work_lo[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opb};
    assign div_ge    = ~div_trial[WIDTH];

    always_comb begin
        step_hi = mul_sum[WIDTH:1];
        step_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
        if (state == DIV) begin
            step_hi = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
            step_lo = {work_lo[WIDTH-2:0], div_ge};
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            hi      <= '0;
            lo      <= '0;
            work_hi <= '0;
            work_lo <= '0;
            opb     <= '0;
            cnt     <= '0;
            ALUout  <= '0;
            Zero    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work_hi <= '0;
                        work_lo <= In1;
                        opb     <= In2;
                        cnt     <= '0;
                        if (Func != F_MULT && Func != F_DIVU) begin
                            ALUout <= alu_res;
                            Zero   <= (alu_res == '0);
                        end
                    end
                end
                MUL, DIV: begin
                    work_hi <= step_hi;
                    work_lo <= step_lo;
                    cnt     <= cnt + 1'b1;
                    if (last) begin
                        hi     <= step_hi;
                        lo     <= step_lo;
                        ALUout <= step_lo;
                        Zero   <= (step_lo == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: a behavioural model pushes expected results
// and latencies; each scenario task pops and compares when the DUT responds.
module tb_alu_mdu;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, out_valid, out_ready, Zero;
    logic [3:0]   Func;
    logic [W-1:0] In1, In2, ALUout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] res;
        int           lat;
    } exp_t;
    exp_t sb[$];

    logic [W-1:0] mhi = '0;
    logic [W-1:0] mlo = '0;

    alu_mdu #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .Func(Func), .In1(In1), .In2(In2), .out_valid(out_valid),
        .out_ready(out_ready), .ALUout(ALUout), .Zero(Zero)
    );

    always #5 clk = ~clk;

    // behavioural reference: uses native * / % rather than iteration
    task automatic expect_op(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        exp_t e;
        e.res = '0;
        case (f)
            4'h0: e.res = a & b;
            4'h1: e.res = a | b;
            4'h2: e.res = a + b;
            4'h3: e.res = a ^ b;
            4'h4: e.res = ~(a | b);
            4'h5: e.res = ($signed(a) < $signed(b)) ? 1 : 0;
            4'h6: e.res = a - b;
            4'h7: e.res = (a < b) ? 1 : 0;
            4'h8: e.res = a << b[4:0];
            4'h9: e.res = a >> b[4:0];
            4'hA: e.res = $signed(a) >>> b[4:0];
            4'hB: e.res = {b[15:0], 16'h0};
            4'hC: begin
                p = {32'h0, a} * {32'h0, b};
                mhi = p[2*W-1:W];
                mlo = p[W-1:0];
                e.res = mlo;
            end
            4'hD: begin
                if (b == 0) begin
                    mlo = '1;
                    mhi = a;
                end else begin
                    mlo = a / b;
                    mhi = a % b;
                end
                e.res = mlo;
            end
            4'hE: e.res = mhi;
            default: e.res = mlo;
        endcase
        e.lat = (f == 4'hC || f == 4'hD) ? W + 1 : 1;
        sb.push_back(e);
    endtask

    // Issues one op from IDLE at a negedge, scrambles inputs while busy,
    // waits (bounded) for out_valid, samples and consumes the result.
    task automatic run_op(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output logic [W-1:0] res, output logic z);
        Func = f; In1 = a; In2 = b; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        Func = 4'($urandom); In1 = $urandom; In2 = $urandom;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            in_valid = 1'($urandom_range(0, 1));
            Func = 4'($urandom); In1 = $urandom; In2 = $urandom;
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        res = ALUout; z = Zero;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        Func = 4'h2; In1 = 32'h1; In2 = 32'h1;
        repeat (3) @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        mhi = '0; mlo = '0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (ALUout !== '0) begin errors++; $display("FAIL reset_ALUout got %h want 0", ALUout); end
        checks++; if (Zero !== 1'b1) begin errors++; $display("FAIL reset_Zero got %b want 1", Zero); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_priority out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_alu();
        logic [3:0]   tf[14] = '{4'h2, 4'h6, 4'h5, 4'h7, 4'h0, 4'h1, 4'h3, 4'h4,
                                 4'h8, 4'h9, 4'hA, 4'hB, 4'hB, 4'h5};
        logic [W-1:0] ta[14] = '{32'h7FFFFFFF, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h0,
                                 32'h1, 32'h80000000, 32'h80000000, 32'h0, 32'hFFFFFFFF, 32'h1};
        logic [W-1:0] tb[14] = '{32'h1, 32'h12345678, 32'h1, 32'h1,
                                 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'h0,
                                 32'h21, 32'h4, 32'h1F, 32'h1234, 32'hABCD5678, 32'hFFFFFFFF};
        int lat; logic [W-1:0] res; logic z; exp_t e;
        for (int i = 0; i < 14; i++) begin
            expect_op(tf[i], ta[i], tb[i]);
            run_op(tf[i], ta[i], tb[i], lat, res, z);
            e = sb.pop_front();
            checks++; if (res !== e.res) begin errors++; $display("FAIL alu_res[%0d] f=%h got %h want %h", i, tf[i], res, e.res); end
            checks++; if (z !== (e.res == 0)) begin errors++; $display("FAIL alu_zero[%0d] got %b want %b", i, z, (e.res == 0)); end
            checks++; if (lat !== e.lat) begin errors++; $display("FAIL alu_lat[%0d] got %0d want %0d", i, lat, e.lat); end
        end
    endtask

    task automatic test_mdu();
        logic [3:0]   tf[13] = '{4'hC, 4'hE, 4'hF, 4'hD, 4'hF, 4'hE, 4'hD, 4'hF, 4'hE,
                                 4'hC, 4'hE, 4'hD, 4'hE};
        logic [W-1:0] ta[13] = '{32'hFFFFFFFF, 0, 0, 32'h64, 0, 0, 32'h64, 0, 0,
                                 32'h00012345, 0, 32'hFFFFFFFF, 0};
        logic [W-1:0] tb[13] = '{32'hFFFFFFFF, 0, 0, 32'h0, 0, 0, 32'h7, 0, 0,
                                 32'h00006789, 0, 32'h1, 0};
        int lat; logic [W-1:0] res; logic z; exp_t e;
        for (int i = 0; i < 13; i++) begin
            expect_op(tf[i], ta[i], tb[i]);
            run_op(tf[i], ta[i], tb[i], lat, res, z);
            e = sb.pop_front();
            checks++; if (res !== e.res) begin errors++; $display("FAIL mdu_res[%0d] f=%h got %h want %h", i, tf[i], res, e.res); end
            checks++; if (z !== (e.res == 0)) begin errors++; $display("FAIL mdu_zero[%0d] got %b want %b", i, z, (e.res == 0)); end
            checks++; if (lat !== e.lat) begin errors++; $display("FAIL mdu_lat[%0d] got %0d want %0d", i, lat, e.lat); end
        end
    endtask

    task automatic test_stall();
        int lat; exp_t e;
        expect_op(4'hA, 32'h80000000, 32'h0000001F);
        Func = 4'hA; In1 = 32'h80000000; In2 = 32'h0000001F; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
        e = sb.pop_front();
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL stall_lat got %0d want %0d", lat, e.lat); end
        for (int k = 0; k < 5; k++) begin
            In1 = $urandom; In2 = $urandom; in_valid = 1'b1;
            checks++; if (ALUout !== e.res) begin errors++; $display("FAIL stall_ALUout[%0d] got %h want %h", k, ALUout, e.res); end
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                errors++; $display("FAIL stall_hs[%0d] got in_ready=%b out_valid=%b want 0/1", k, in_ready, out_valid); end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++; if (ALUout !== e.res) begin errors++; $display("FAIL stall_final got %h want %h", ALUout, e.res); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        expect_op(4'h3, 32'hAAAA5555, 32'h0F0F0F0F);
        expect_op(4'h2, 32'h1, 32'h1);
        Func = 4'h3; In1 = 32'hAAAA5555; In2 = 32'h0F0F0F0F; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        e = sb.pop_front();
        checks++; if (out_valid !== 1'b1 || ALUout !== e.res) begin
            errors++; $display("FAIL b2b_first got v=%b %h want 1 %h", out_valid, ALUout, e.res); end
        // consume and offer the next op in the same cycle: must not be taken yet
        Func = 4'h2; In1 = 32'h1; In2 = 32'h1; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_nobypass got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        e = sb.pop_front();
        checks++; if (out_valid !== 1'b1 || ALUout !== e.res) begin
            errors++; $display("FAIL b2b_second got v=%b %h want 1 %h", out_valid, ALUout, e.res); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_mul();
        int seen = 0; int lat; logic [W-1:0] res; logic z; exp_t e;
        Func = 4'hC; In1 = 32'h0000ABCD; In2 = 32'h00001234; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mhi = '0; mlo = '0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid got %b want 0", out_valid); end
        checks++; if (Zero !== 1'b1) begin errors++; $display("FAIL abort_Zero got %b want 1", Zero); end
        repeat (40) begin @(negedge clk); if (out_valid === 1'b1) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_result got %0d valid cycles want 0", seen); end
        expect_op(4'hF, 0, 0);
        run_op(4'hF, 0, 0, lat, res, z);
        e = sb.pop_front();
        checks++; if (res !== e.res) begin errors++; $display("FAIL abort_mflo got %h want %h", res, e.res); end
        expect_op(4'hE, 0, 0);
        run_op(4'hE, 0, 0, lat, res, z);
        e = sb.pop_front();
        checks++; if (res !== e.res) begin errors++; $display("FAIL abort_mfhi got %h want %h", res, e.res); end
    endtask

    task automatic test_random();
        int lat; logic [W-1:0] res; logic z; exp_t e;
        logic [3:0] f; logic [W-1:0] a, b;
        for (int i = 0; i < 30; i++) begin
            f = 4'($urandom);
            a = $urandom;
            b = (i % 5 == 0) ? W'($urandom_range(0, 40)) : $urandom;
            expect_op(f, a, b);
            run_op(f, a, b, lat, res, z);
            e = sb.pop_front();
            checks++; if (res !== e.res || lat !== e.lat) begin
                errors++; $display("FAIL rand[%0d] f=%h a=%h b=%h got %h/%0d want %h/%0d", i, f, a, b, res, lat, e.res, e.lat); end
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        Func = '0; In1 = '0; In2 = '0;
        @(negedge clk);
        test_reset();
        test_alu();
        test_mdu();
        test_stall();
        test_back_to_back();
        test_reset_mid_mul();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width (WIDTH >= 8, power of two).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), meaning shift-amount width.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  block can accept an operation.
REQ-007 SHALL have port Func  input  4  operation select.
REQ-008 SHALL have ports In1, In2  input  WIDTH  operands.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port ALUout  output  WIDTH  registered result.
REQ-012 SHALL have port Zero  output  1  registered flag, 1 when ALUout == 0.

Function
REQ-013 SHALL accept an operation on a cycle with in_valid && in_ready, capturing Func/In1/In2.
REQ-014 SHALL implement FSM IDLE, MUL, DIV, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-015 SHALL decode Func: 0 AND, 1 OR, 2 ADD, 3 XOR, 4 NOR, 5 SLT signed, 6 SUB, 7 SLTU, 8 SLL, 9 SRL, A SRA, B LUI-style (In2 << WIDTH/2), C MULTU, D DIVU, E MFHI, F MFLO.
REQ-016 SHALL wrap ADD/SUB modulo 2^WIDTH, no overflow flag; SLT/SLTU yield 1 or 0 zero-extended.
REQ-017 SHALL shift In1 by In2[SHW-1:0] for SLL/SRL/SRA; SRA sign-fills.
REQ-018 SHALL move IDLE->DONE on acceptance of Func 0-B, E, F; result registered, out_valid on cycle after acceptance (latency 1).
REQ-019 SHALL move IDLE->MUL on MULTU: shift-add, one bit per cycle, exactly WIDTH cycles, then DONE; out_valid WIDTH+1 cycles after acceptance.
REQ-020 SHALL move IDLE->DIV on DIVU: restoring division, one bit per cycle, exactly WIDTH cycles, then DONE; same latency as MULTU.
REQ-021 SHALL hold internal HI, LO registers (WIDTH each); MULTU writes {HI,LO} = 2*WIDTH-bit unsigned product; DIVU writes LO = quotient, HI = remainder; written on MUL/DIV->DONE transition only.
REQ-022 SHALL drive ALUout = LO for MULTU/DIVU, HI for MFHI, LO for MFLO.
REQ-023 SHALL, for DIVU with In2 == 0, produce LO = all ones, HI = In1, same WIDTH+1 latency.
REQ-024 SHALL compute MFHI/MFLO from HI/LO as of acceptance cycle.
REQ-025 SHALL hold ALUout, Zero, out_valid stable in DONE until out_ready; DONE->IDLE on out_ready.
REQ-026 SHALL NOT accept a new operation in the DONE->IDLE cycle (no bypass); next acceptance at earliest one cycle later.
REQ-027 SHALL ignore in_valid while not in IDLE; Func/In1/In2 changes during MUL/DIV SHALL NOT affect result.

Reset
REQ-028 SHALL on reset go to IDLE, in_ready = 1, out_valid = 0, ALUout = 0, Zero = 1, HI = LO = 0.
REQ-029 SHALL on reset mid MUL/DIV abort the operation, leaving HI/LO = 0 and no out_valid.
REQ-030 SHALL give reset priority over in_valid and out_ready in the same cycle.

Verification
REQ-031 WIDTH=32, Func=2, In1=7FFFFFFF, In2=1, out_ready=1 -> cycle+1 out_valid=1, ALUout=80000000, Zero=0.
REQ-032 Func=6, In1=In2=12345678 -> ALUout=0, Zero=1; Func=5, In1=FFFFFFFF, In2=1 -> ALUout=1; Func=7 same operands -> ALUout=0.
REQ-033 Func=C, In1=In2=FFFFFFFF -> out_valid exactly 33 cycles after acceptance, ALUout=00000001; then Func=E -> ALUout=FFFFFFFE.
REQ-034 Func=D, In1=64, In2=0 -> LO=FFFFFFFF, HI=00000064 (check via F, E); Func=D, In1=64, In2=7 -> LO=E, HI=2.
REQ-035 Func=A, In1=80000000, In2=0000001F -> FFFFFFFF; out_ready held 0 for 5 cycles -> ALUout stable, in_ready=0 throughout.
REQ-036 reset asserted 10 cycles into MULTU -> next cycle in_ready=1, out_valid=0, Zero=1; Func=F -> ALUout=0.
